// File: rtl/plic_claim_arb.sv
// Claim/complete sequencer between PLIC targets and the shared per-source gateways.
// One claim is arbitrated round-robin per slot; completions are checked against the in-service table.
module plic_claim_arb #(
  parameter int unsigned IRQ_NUM   = 32,
  parameter int unsigned IRQ_WIDTH = 5,
  parameter int unsigned TGT_NUM   = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [TGT_NUM-1:0]             cand_vld_i,
  input  logic [TGT_NUM*IRQ_WIDTH-1:0]   cand_id_i,
  input  logic [IRQ_NUM-1:0]             ip_i,
  input  logic [TGT_NUM-1:0]             claim_req_i,
  output logic [TGT_NUM-1:0]             claim_ack_o,
  output logic [TGT_NUM*IRQ_WIDTH-1:0]   claim_id_o,
  input  logic [TGT_NUM-1:0]             comp_req_i,
  input  logic [TGT_NUM*IRQ_WIDTH-1:0]   comp_id_i,
  output logic [TGT_NUM-1:0]             comp_ack_o,
  output logic [TGT_NUM-1:0]             comp_err_o,
  output logic [IRQ_NUM-1:0]             gw_clam_o,
  output logic [IRQ_NUM-1:0]             gw_comp_o,
  output logic                           busy_o
);

  localparam int unsigned TgtW = (TGT_NUM > 1) ? $clog2(TGT_NUM) : 1;

  typedef logic [IRQ_WIDTH-1:0] id_t;
  typedef logic [TgtW-1:0]      tgt_t;
  typedef enum logic [1:0] {StIdle, StCheck, StResp} state_e;

  state_e                              state_q, state_d;
  logic [TGT_NUM-1:0]                  pend_q, pend_d;
  tgt_t                                rr_q, rr_d;
  tgt_t                                gnt_q, gnt_d;
  id_t                                 rsp_id_q, rsp_id_d;
  logic                                holdoff_q, holdoff_d;
  logic [TGT_NUM-1:0][IRQ_WIDTH-1:0]   claim_id_q, claim_id_d, claim_id_out;
  logic [IRQ_NUM-1:0]                  insvc_q, insvc_d;
  logic [IRQ_NUM-1:0][TgtW-1:0]        owner_q, owner_d;
  logic [TGT_NUM-1:0]                  comp_ack_q, comp_ack_d;
  logic [TGT_NUM-1:0]                  comp_err_q, comp_err_d;
  logic [IRQ_NUM-1:0]                  gw_comp_q, gw_comp_d;

  logic [TGT_NUM-1:0][IRQ_WIDTH-1:0]   cand_id, comp_id;
  logic                                hi_vld, lo_vld, arb_vld;
  tgt_t                                hi_idx, lo_idx, arb_idx;
  id_t                                 chk_id;
  logic                                chk_ok;
  logic                                set_vld;

  assign cand_id = cand_id_i;
  assign comp_id = comp_id_i;

  // Round-robin: first pending target at or above rr_q, else the first pending one overall.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int unsigned i = 0; i < TGT_NUM; i++) begin
      if (pend_q[i] && !hi_vld && (i >= 32'(rr_q))) begin
        hi_vld = 1'b1;
        hi_idx = tgt_t'(i);
      end
      if (pend_q[i] && !lo_vld) begin
        lo_vld = 1'b1;
        lo_idx = tgt_t'(i);
      end
    end
    arb_vld = hi_vld | lo_vld;
    arb_idx = hi_vld ? hi_idx : lo_idx;
  end

  assign chk_id = cand_id[gnt_q];
  assign chk_ok = cand_vld_i[gnt_q] && (chk_id != '0) && (32'(chk_id) < IRQ_NUM) && ip_i[chk_id];

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q | claim_req_i;
    rr_d         = rr_q;
    gnt_d        = gnt_q;
    rsp_id_d     = rsp_id_q;
    holdoff_d    = 1'b0;
    claim_id_d   = claim_id_q;
    claim_id_out = claim_id_q;
    claim_ack_o  = '0;
    gw_clam_o    = '0;
    set_vld      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The dwell cycle after RESP keeps every claim slot exactly four cycles long.
        if (arb_vld && !holdoff_q) begin
          gnt_d   = arb_idx;
          rr_d    = (32'(arb_idx) == TGT_NUM - 1) ? '0 : arb_idx + 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (chk_ok) begin
          gw_clam_o[chk_id] = 1'b1;
          set_vld           = 1'b1;
          rsp_id_d          = chk_id;
        end else begin
          rsp_id_d = '0;
        end
        state_d = StResp;
      end
      StResp: begin
        claim_ack_o[gnt_q]  = 1'b1;
        claim_id_out[gnt_q] = rsp_id_q;
        claim_id_d[gnt_q]   = rsp_id_q;
        pend_d[gnt_q]       = 1'b0;
        holdoff_d           = 1'b1;
        state_d             = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    insvc_d    = insvc_q;
    owner_d    = owner_q;
    comp_ack_d = comp_req_i;
    comp_err_d = '0;
    gw_comp_d  = '0;
    for (int unsigned t = 0; t < TGT_NUM; t++) begin
      if (comp_req_i[t]) begin
        if ((32'(comp_id[t]) < IRQ_NUM) && insvc_q[comp_id[t]] &&
            (owner_q[comp_id[t]] == tgt_t'(t))) begin
          gw_comp_d[comp_id[t]] = 1'b1;
          insvc_d[comp_id[t]]   = 1'b0;
        end else begin
          comp_err_d[t] = 1'b1;
        end
      end
    end
    // A claim landing on the same source as a completion takes priority.
    if (set_vld) begin
      insvc_d[chk_id] = 1'b1;
      owner_d[chk_id] = gnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      pend_q     <= '0;
      rr_q       <= '0;
      gnt_q      <= '0;
      rsp_id_q   <= '0;
      holdoff_q  <= 1'b0;
      claim_id_q <= '0;
      insvc_q    <= '0;
      owner_q    <= '0;
      comp_ack_q <= '0;
      comp_err_q <= '0;
      gw_comp_q  <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      rsp_id_q   <= rsp_id_d;
      holdoff_q  <= holdoff_d;
      claim_id_q <= claim_id_d;
      insvc_q    <= insvc_d;
      owner_q    <= owner_d;
      comp_ack_q <= comp_ack_d;
      comp_err_q <= comp_err_d;
      gw_comp_q  <= gw_comp_d;
    end
  end

  assign claim_id_o = claim_id_out;
  assign comp_ack_o = comp_ack_q;
  assign comp_err_o = comp_err_q;
  assign gw_comp_o  = gw_comp_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_plic_claim_arb.sv
// Bench for plic_claim_arb: directed claim table, hand-written corner sequences,
// then randomized traffic against a cycle-timestamp reference model.
module tb_plic_claim_arb;
  localparam int N = 32;
  localparam int W = 5;
  localparam int T = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [T-1:0]     cand_vld_i = '0;
  logic [T*W-1:0]   cand_id_i = '0;
  logic [N-1:0]     ip_i = '0;
  logic [T-1:0]     claim_req_i = '0;
  logic [T-1:0]     claim_ack_o;
  logic [T*W-1:0]   claim_id_o;
  logic [T-1:0]     comp_req_i = '0;
  logic [T*W-1:0]   comp_id_i = '0;
  logic [T-1:0]     comp_ack_o;
  logic [T-1:0]     comp_err_o;
  logic [N-1:0]     gw_clam_o;
  logic [N-1:0]     gw_comp_o;
  logic             busy_o;

  int n_chk = 0;
  int n_err = 0;

  plic_claim_arb #(.IRQ_NUM(N), .IRQ_WIDTH(W), .TGT_NUM(T)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cand_vld_i(cand_vld_i), .cand_id_i(cand_id_i), .ip_i(ip_i),
    .claim_req_i(claim_req_i), .claim_ack_o(claim_ack_o), .claim_id_o(claim_id_o),
    .comp_req_i(comp_req_i), .comp_id_i(comp_id_i), .comp_ack_o(comp_ack_o),
    .comp_err_o(comp_err_o), .gw_clam_o(gw_clam_o), .gw_comp_o(gw_comp_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tgt;
    bit vld;
    int id;
    bit ipb;
    int exp_id;
  } claim_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] id_slice(input logic [T*W-1:0] v, input int t);
    return 32'(v[t*W +: W]);
  endfunction

  // Single uncontended claim: gateway pulse in cycle 2, ack in cycle 3.
  task automatic run_claim(input claim_vec_t v);
    logic [31:0] exp_clam;
    exp_clam = (v.exp_id != 0) ? (32'd1 << v.exp_id) : 32'd0;
    cand_vld_i = '0;
    cand_vld_i[v.tgt] = v.vld;
    cand_id_i = '0;
    cand_id_i[v.tgt*W +: W] = W'(v.id);
    ip_i = v.ipb ? (32'd1 << v.id) : 32'd0;
    claim_req_i = '0;
    claim_req_i[v.tgt] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 2) chk("claim gw_clam", gw_clam_o, exp_clam);
      if (c == 3) begin
        chk("claim ack", 32'(claim_ack_o), 32'd1 << v.tgt);
        chk("claim id", id_slice(claim_id_o, v.tgt), 32'(v.exp_id));
      end
      tick();
      claim_req_i = '0;
    end
    tick();
  endtask

  task automatic do_comp(input string name, input logic [1:0] req, input int id0, input int id1,
                         input logic [1:0] exp_err, input logic [31:0] exp_gw);
    comp_req_i = req;
    comp_id_i = {W'(id1), W'(id0)};
    tick();
    comp_req_i = '0;
    @(negedge clk);
    chk({name, " ack"}, 32'(comp_ack_o), 32'(req));
    chk({name, " err"}, 32'(comp_err_o), 32'(exp_err));
    chk({name, " gw_comp"}, gw_comp_o, exp_gw);
    tick();
  endtask

  task automatic random_phase(input int ncyc);
    bit          m_pend[T];
    bit          m_act;
    int          m_gc, m_g, m_rr, m_nok, m_rsp;
    int          m_held[T];
    bit          m_insvc[N];
    int          m_own[N];
    logic [1:0]  m_cack, m_cerr, n_cack, n_cerr;
    logic [31:0] m_gwc, n_gwc;
    logic [31:0] e_clam, e_ack, e_busy;
    int          e_id[T];
    bit          valid, resp, found;
    int          cid, id, idx;
    m_act = 0; m_gc = -10; m_g = 0; m_rr = 0; m_nok = 0; m_rsp = 0;
    m_cack = '0; m_cerr = '0; m_gwc = '0;
    for (int t = 0; t < T; t++) begin
      m_pend[t] = 0;
      m_held[t] = 0;
    end
    for (int i = 0; i < N; i++) begin
      m_insvc[i] = 0;
      m_own[i] = 0;
    end
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      for (int t = 0; t < T; t++) begin
        cand_vld_i[t] = ($urandom_range(0, 3) != 0);
        cand_id_i[t*W +: W] = ($urandom_range(0, 9) == 0) ? W'(31) : W'($urandom_range(0, 7));
        claim_req_i[t] = ($urandom_range(0, 2) == 0);
        comp_req_i[t] = ($urandom_range(0, 2) == 0);
        comp_id_i[t*W +: W] = W'($urandom_range(0, 7));
      end
      ip_i = $urandom | $urandom;
      @(negedge clk);
      e_clam = '0; e_ack = '0; e_busy = '0; valid = 0; cid = 0;
      for (int t = 0; t < T; t++) e_id[t] = m_held[t];
      if (m_act && cyc == m_gc + 1) begin
        cid = int'(cand_id_i[m_g*W +: W]);
        valid = cand_vld_i[m_g] && cid != 0 && ip_i[cid];
        if (valid) e_clam = 32'd1 << cid;
        e_busy = 1;
      end
      if (m_act && cyc == m_gc + 2) begin
        e_ack = 32'd1 << m_g;
        e_id[m_g] = m_rsp;
        e_busy = 1;
      end
      chk("rnd gw_clam", gw_clam_o, e_clam);
      chk("rnd claim_ack", 32'(claim_ack_o), e_ack);
      chk("rnd claim_id0", id_slice(claim_id_o, 0), 32'(e_id[0]));
      chk("rnd claim_id1", id_slice(claim_id_o, 1), 32'(e_id[1]));
      chk("rnd busy", 32'(busy_o), e_busy);
      chk("rnd comp_ack", 32'(comp_ack_o), 32'(m_cack));
      chk("rnd comp_err", 32'(comp_err_o), 32'(m_cerr));
      chk("rnd gw_comp", gw_comp_o, m_gwc);
      // Advance the model by one clock.
      n_cack = comp_req_i; n_cerr = '0; n_gwc = '0;
      for (int t = 0; t < T; t++) begin
        if (comp_req_i[t]) begin
          id = int'(comp_id_i[t*W +: W]);
          if (m_insvc[id] && m_own[id] == t) begin
            n_gwc[id] = 1'b1;
            m_insvc[id] = 0;
          end else begin
            n_cerr[t] = 1'b1;
          end
        end
      end
      if (m_act && cyc == m_gc + 1) begin
        if (valid) begin
          m_insvc[cid] = 1;
          m_own[cid] = m_g;
          m_rsp = cid;
        end else begin
          m_rsp = 0;
        end
      end
      resp = m_act && cyc == m_gc + 2;
      if (!m_act && cyc >= m_nok) begin
        found = 0;
        for (int k = 0; k < T; k++) begin
          idx = (m_rr + k) % T;
          if (!found && m_pend[idx]) begin
            found = 1;
            m_g = idx;
            m_rr = (idx + 1) % T;
            m_gc = cyc;
            m_act = 1;
          end
        end
      end
      for (int t = 0; t < T; t++) if (claim_req_i[t]) m_pend[t] = 1;
      if (resp) begin
        m_held[m_g] = m_rsp;
        m_pend[m_g] = 0;
        m_act = 0;
        m_nok = cyc + 2;
      end
      m_cack = n_cack; m_cerr = n_cerr; m_gwc = n_gwc;
      tick();
    end
  endtask

  initial begin
    claim_vec_t tbl[6];
    tbl[0] = '{tgt: 0, vld: 1, id: 7,  ipb: 1, exp_id: 7};
    tbl[1] = '{tgt: 1, vld: 0, id: 9,  ipb: 1, exp_id: 0};
    tbl[2] = '{tgt: 1, vld: 1, id: 9,  ipb: 0, exp_id: 0};
    tbl[3] = '{tgt: 1, vld: 1, id: 0,  ipb: 1, exp_id: 0};
    tbl[4] = '{tgt: 1, vld: 1, id: 12, ipb: 1, exp_id: 12};
    tbl[5] = '{tgt: 0, vld: 1, id: 31, ipb: 1, exp_id: 31};

    #2;
    chk("reset ctrl outs", {17'd0, claim_ack_o, claim_id_o, comp_ack_o, comp_err_o, busy_o}, 32'd0);
    chk("reset gw_clam", gw_clam_o, 32'd0);
    chk("reset gw_comp", gw_comp_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_claim(tbl[i]);

    // In service now: 7 and 31 owned by target 0, 12 owned by target 1.
    do_comp("comp own",         2'b01, 7, 0,  2'b00, 32'd1 << 7);
    do_comp("comp freed",       2'b10, 0, 7,  2'b10, 32'd0);
    do_comp("comp other owner", 2'b10, 0, 31, 2'b10, 32'd0);
    do_comp("comp id0",         2'b01, 0, 0,  2'b01, 32'd0);
    do_comp("comp parallel",    2'b11, 31, 12, 2'b00, (32'd1 << 31) | (32'd1 << 12));

    // Target 1 claims 5 while target 0 completes 5 during CHECK.
    run_claim('{tgt: 0, vld: 1, id: 5, ipb: 1, exp_id: 5});
    cand_vld_i = 2'b10;
    cand_id_i = {W'(5), W'(0)};
    ip_i = 32'd1 << 5;
    claim_req_i = 2'b10;
    tick();
    claim_req_i = '0;
    tick();
    comp_req_i = 2'b01;
    comp_id_i = {W'(0), W'(5)};
    @(negedge clk);
    chk("steal gw_clam", gw_clam_o, 32'd1 << 5);
    tick();
    comp_req_i = '0;
    @(negedge clk);
    chk("steal claim_ack", 32'(claim_ack_o), 32'd2);
    chk("steal claim_id", id_slice(claim_id_o, 1), 32'd5);
    chk("steal comp_err", 32'(comp_err_o), 32'd0);
    chk("steal gw_comp", gw_comp_o, 32'd1 << 5);
    tick();
    tick();
    do_comp("comp old owner", 2'b01, 5, 0, 2'b01, 32'd0);
    do_comp("comp new owner", 2'b10, 0, 5, 2'b00, 32'd1 << 5);

    // Reset asserted while a claim sits in CHECK.
    cand_vld_i = 2'b01;
    cand_id_i = {W'(0), W'(9)};
    ip_i = 32'd1 << 9;
    claim_req_i = 2'b01;
    tick();
    claim_req_i = '0;
    tick();
    @(negedge clk);
    chk("rst busy in check", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst ctrl outs", {17'd0, claim_ack_o, claim_id_o, comp_ack_o, comp_err_o, busy_o}, 32'd0);
    chk("rst gw_clam", gw_clam_o, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst dropped ack", 32'(claim_ack_o), 32'd0);
      tick();
    end

    // Contention from rr_ptr = 0: target 0 in cycle 3, target 1 in cycle 7.
    cand_vld_i = 2'b11;
    cand_id_i = {W'(4), W'(3)};
    ip_i = (32'd1 << 3) | (32'd1 << 4);
    claim_req_i = 2'b11;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 3) begin
        chk("cont ack t0", 32'(claim_ack_o), 32'd1);
        chk("cont id t0", id_slice(claim_id_o, 0), 32'd3);
      end else if (c == 7) begin
        chk("cont ack t1", 32'(claim_ack_o), 32'd2);
        chk("cont id t1", id_slice(claim_id_o, 1), 32'd4);
        chk("cont hold t0", id_slice(claim_id_o, 0), 32'd3);
      end else begin
        chk("cont idle ack", 32'(claim_ack_o), 32'd0);
      end
      tick();
      claim_req_i = '0;
    end

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    random_phase(600);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
